// File: rtl/rs_encode_stream_pkg.sv
// Shared types and block geometry for the Reed-Solomon stream encoder controllers.
package rs_encode_stream_pkg;

  // Default block geometry: data-region lines (real data plus pad) and parity lines per block.
  localparam int RS_DATA_LINES   = 4;
  localparam int RS_PARITY_LINES = 2;

  typedef enum logic [2:0] {
    READY,
    SEND_META,
    DATA_LINES,
    DRAIN_PAD,
    PARITY_LINES
  } out_state_e;

  typedef enum logic [1:0] {
    IN_READY,
    IN_RECV_META,
    IN_FILL_LINES,
    IN_WAIT_OUT
  } in_state_e;

endpackage

// File: rtl/rs_unit_sel_ctr.sv
// Round-robin RS unit selector: clears to 0, advances on incr, wraps at NUM_UNITS-1.
module rs_unit_sel_ctr #(
  parameter int NUM_UNITS = 4,
  parameter int SEL_W     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             incr,
  output logic [SEL_W-1:0] sel
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_UNITS - 1);

  logic [SEL_W-1:0] sel_q, sel_d;

  always_comb begin
    sel_d = sel_q;
    if (clr) begin
      sel_d = '0;
    end else if (incr) begin
      sel_d = (sel_q == LAST_SEL) ? '0 : sel_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel_d;
    end
  end

  assign sel = sel_q;

endmodule

// File: rtl/rs_encode_stream_out_ctrl.sv
// Output-side control FSM of the RS stream encoder; rst is asynchronous, active-low.
// Optional RS_OUT_CTRL_PERF_EN adds saturating block and destination-stall counters.
module rs_encode_stream_out_ctrl
  import rs_encode_stream_pkg::*;
#(
  parameter int NUM_RS_UNITS   = 4,
  parameter int NUM_RS_UNITS_W = (NUM_RS_UNITS > 1) ? $clog2(NUM_RS_UNITS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_ctrl_out_ctrl_val,
  output logic                      out_ctrl_in_ctrl_rdy,
  output logic                      out_ctrl_out_datap_store_meta,
  output logic                      out_ctrl_out_datap_init_line_count,
  output logic                      out_ctrl_out_datap_incr_line_count,
  output logic                      out_ctrl_out_datap_init_block_count,
  output logic                      out_ctrl_out_datap_incr_block_count,
  input  logic                      out_datap_out_ctrl_last_data_line,
  input  logic                      out_datap_out_ctrl_last_pad_line,
  input  logic                      out_datap_out_ctrl_last_parity_line,
  input  logic                      out_datap_out_ctrl_last_block,
  output logic [NUM_RS_UNITS_W-1:0] out_ctrl_rs_unit_sel,
  input  logic                      line_encode_stream_encode_val,
  output logic                      stream_encode_line_encode_rdy,
  output logic                      stream_encoder_dst_resp_val,
  input  logic                      dst_stream_encoder_resp_rdy,
  output logic                      stream_encoder_dst_resp_data_val,
  input  logic                      dst_stream_encoder_resp_data_rdy
`ifdef RS_OUT_CTRL_PERF_EN
  ,
  output logic [31:0]               perf_blocks_sent,
  output logic [31:0]               perf_dst_stall_cycles
`endif
);

  out_state_e state_q, state_d;
  logic       sel_clr, sel_incr;
  logic       data_xfer;

  assign data_xfer = line_encode_stream_encode_val & dst_stream_encoder_resp_data_rdy;

  always_comb begin
    state_d                             = state_q;
    sel_clr                             = 1'b0;
    sel_incr                            = 1'b0;
    out_ctrl_in_ctrl_rdy                = 1'b0;
    out_ctrl_out_datap_store_meta       = 1'b0;
    out_ctrl_out_datap_init_line_count  = 1'b0;
    out_ctrl_out_datap_incr_line_count  = 1'b0;
    out_ctrl_out_datap_init_block_count = 1'b0;
    out_ctrl_out_datap_incr_block_count = 1'b0;
    stream_encode_line_encode_rdy       = 1'b0;
    stream_encoder_dst_resp_val         = 1'b0;
    stream_encoder_dst_resp_data_val    = 1'b0;
    case (state_q)
      READY: begin
        out_ctrl_in_ctrl_rdy                = 1'b1;
        out_ctrl_out_datap_store_meta       = 1'b1;
        out_ctrl_out_datap_init_line_count  = 1'b1;
        out_ctrl_out_datap_init_block_count = 1'b1;
        sel_clr                             = 1'b1;
        if (in_ctrl_out_ctrl_val) state_d = SEND_META;
      end
      SEND_META: begin
        stream_encoder_dst_resp_val = 1'b1;
        if (dst_stream_encoder_resp_rdy) state_d = DATA_LINES;
      end
      DATA_LINES: begin
        stream_encoder_dst_resp_data_val = line_encode_stream_encode_val;
        stream_encode_line_encode_rdy    = dst_stream_encoder_resp_data_rdy;
        if (data_xfer) begin
          out_ctrl_out_datap_incr_line_count = 1'b1;
          if (out_datap_out_ctrl_last_data_line) begin
            state_d = out_datap_out_ctrl_last_pad_line ? PARITY_LINES : DRAIN_PAD;
          end
        end
      end
      DRAIN_PAD: begin
        // Pads never reach the destination, so they drain regardless of its backpressure.
        stream_encode_line_encode_rdy = 1'b1;
        if (line_encode_stream_encode_val) begin
          out_ctrl_out_datap_incr_line_count = 1'b1;
          if (out_datap_out_ctrl_last_pad_line) state_d = PARITY_LINES;
        end
      end
      PARITY_LINES: begin
        stream_encoder_dst_resp_data_val = line_encode_stream_encode_val;
        stream_encode_line_encode_rdy    = dst_stream_encoder_resp_data_rdy;
        if (data_xfer) begin
          if (out_datap_out_ctrl_last_parity_line) begin
            out_ctrl_out_datap_init_line_count  = 1'b1;
            out_ctrl_out_datap_incr_block_count = 1'b1;
            if (out_datap_out_ctrl_last_block) begin
              state_d = READY;
            end else begin
              sel_incr = 1'b1;
              state_d  = DATA_LINES;
            end
          end else begin
            out_ctrl_out_datap_incr_line_count = 1'b1;
          end
        end
      end
      default: begin
        state_d                             = out_state_e'('x);
        sel_clr                             = 1'bx;
        sel_incr                            = 1'bx;
        out_ctrl_in_ctrl_rdy                = 1'bx;
        out_ctrl_out_datap_store_meta       = 1'bx;
        out_ctrl_out_datap_init_line_count  = 1'bx;
        out_ctrl_out_datap_incr_line_count  = 1'bx;
        out_ctrl_out_datap_init_block_count = 1'bx;
        out_ctrl_out_datap_incr_block_count = 1'bx;
        stream_encode_line_encode_rdy       = 1'bx;
        stream_encoder_dst_resp_val         = 1'bx;
        stream_encoder_dst_resp_data_val    = 1'bx;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= READY;
    end else begin
      state_q <= state_d;
    end
  end

  rs_unit_sel_ctr #(
    .NUM_UNITS (NUM_RS_UNITS),
    .SEL_W     (NUM_RS_UNITS_W)
  ) u_unit_sel (
    .clk  (clk),
    .rst  (rst),
    .clr  (sel_clr),
    .incr (sel_incr),
    .sel  (out_ctrl_rs_unit_sel)
  );

`ifdef RS_OUT_CTRL_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] blocks_q, blocks_d;
  logic [31:0] stalls_q, stalls_d;

  always_comb begin
    blocks_d = blocks_q;
    stalls_d = stalls_q;
    if (out_ctrl_out_datap_incr_block_count) blocks_d = sat_inc(blocks_q);
    if (stream_encoder_dst_resp_data_val && !dst_stream_encoder_resp_data_rdy) begin
      stalls_d = sat_inc(stalls_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blocks_q <= '0;
      stalls_q <= '0;
    end else begin
      blocks_q <= blocks_d;
      stalls_q <= stalls_d;
    end
  end

  assign perf_blocks_sent      = blocks_q;
  assign perf_dst_stall_cycles = stalls_q;
`endif

endmodule

// File: tb/tb_rs_encode_stream_out_ctrl.sv
// Randomized bench for rs_encode_stream_out_ctrl against a slot-level stream model.
module tb_rs_encode_stream_out_ctrl;
  import rs_encode_stream_pkg::*;

  localparam int N  = 3;
  localparam int SW = 2;
  localparam int DL = RS_DATA_LINES;
  localparam int SL = RS_DATA_LINES + RS_PARITY_LINES;
  localparam int PH_IDLE = 0, PH_HDR = 1, PH_STR = 2;
  localparam logic [8:0] V_READY = 9'b111010000;
  localparam logic [8:0] V_HDR   = 9'b000000100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_val, ctrl_rdy, store, initl, incrl, initb, incrb;
  logic last_data, last_pad, last_par, last_blk;
  logic [SW-1:0] sel;
  logic uval, urdy, resp_val, resp_rdy, dval, drdy;
`ifdef RS_OUT_CTRL_PERF_EN
  logic [31:0] perf_b, perf_s;
`endif

  rs_encode_stream_out_ctrl #(.NUM_RS_UNITS(N)) dut (
    .clk                                 (clk),
    .rst                                 (rst),
    .in_ctrl_out_ctrl_val                (in_val),
    .out_ctrl_in_ctrl_rdy                (ctrl_rdy),
    .out_ctrl_out_datap_store_meta       (store),
    .out_ctrl_out_datap_init_line_count  (initl),
    .out_ctrl_out_datap_incr_line_count  (incrl),
    .out_ctrl_out_datap_init_block_count (initb),
    .out_ctrl_out_datap_incr_block_count (incrb),
    .out_datap_out_ctrl_last_data_line   (last_data),
    .out_datap_out_ctrl_last_pad_line    (last_pad),
    .out_datap_out_ctrl_last_parity_line (last_par),
    .out_datap_out_ctrl_last_block       (last_blk),
    .out_ctrl_rs_unit_sel                (sel),
    .line_encode_stream_encode_val       (uval),
    .stream_encode_line_encode_rdy       (urdy),
    .stream_encoder_dst_resp_val         (resp_val),
    .dst_stream_encoder_resp_rdy         (resp_rdy),
    .stream_encoder_dst_resp_data_val    (dval),
    .dst_stream_encoder_resp_data_rdy    (drdy)
`ifdef RS_OUT_CTRL_PERF_EN
    ,
    .perf_blocks_sent                    (perf_b),
    .perf_dst_stall_cycles               (perf_s)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, passes = 0;
  int phase = PH_IDLE, nb = 0, blk = 0, slot = 0, req_seq = 0;
  logic [63:0] cur_d = '0;
  int req_nb_q[$];
  logic [63:0] req_d_q[$];
  int exp_ids[$];
  int sel_log[$];
  int dst_count = 0, hdr_cycles = 0;
  int unsigned exp_blocks = 0, exp_stalls = 0;
  int p_uval = 100, p_drdy = 100, p_hrdy = 100, stall_budget = 0, hdr_hold = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic push_req(input int n, input logic [63:0] d);
    req_nb_q.push_back(n);
    req_d_q.push_back(d);
  endtask

  function automatic logic [8:0] outs_vec();
    return {ctrl_rdy, store, initl, incrl, initb, incrb, resp_val, dval, urdy};
  endfunction

  task automatic step();
    logic [8:0] ev;
    logic pad, xfer, ex_urdy, ex_dval;
    int d, cur_id;
    @(negedge clk);
    in_val = (req_nb_q.size() != 0);
    uval   = ($urandom_range(99) < p_uval);
    d      = (phase == PH_STR) ? int'(cur_d[blk*4 +: 4]) : 0;
    pad    = (phase == PH_STR) && (slot >= d) && (slot < DL);
    if (stall_budget > 0 && phase == PH_STR && !pad && uval) begin
      drdy = 1'b0;
      stall_budget--;
    end else begin
      drdy = ($urandom_range(99) < p_drdy);
    end
    if (hdr_hold > 0 && phase == PH_HDR) begin
      resp_rdy = 1'b0;
      hdr_hold--;
    end else begin
      resp_rdy = ($urandom_range(99) < p_hrdy);
    end
    if (phase == PH_STR && uval) begin
      last_data = (slot == d - 1);
      last_pad  = (slot == DL - 1);
      last_par  = (slot == SL - 1);
      last_blk  = (blk == nb - 1);
    end else begin
      {last_data, last_pad, last_par, last_blk} = 4'($urandom);
    end
    #1;
    ex_dval = 1'b0;
    ex_urdy = 1'b0;
    xfer    = 1'b0;
    if (phase == PH_IDLE) ev = V_READY;
    else if (phase == PH_HDR) ev = V_HDR;
    else if (pad) begin
      ex_urdy = 1'b1;
      ev = {3'b000, uval, 5'b00001};
    end else begin
      ex_dval = uval;
      ex_urdy = drdy;
      xfer    = uval & drdy;
      ev = {2'b00, xfer && slot == SL - 1, xfer && slot != SL - 1, 1'b0,
            xfer && slot == SL - 1, 1'b0, uval, drdy};
    end
    chk("outputs", 32'(outs_vec()), 32'(ev));
    if (phase != PH_IDLE) chk("unit_sel", 32'(sel), blk % N);
`ifdef RS_OUT_CTRL_PERF_EN
    chk("perf_blocks", perf_b, exp_blocks);
    chk("perf_stalls", perf_s, exp_stalls);
`endif
    if (phase == PH_HDR) hdr_cycles++;
    cur_id = req_seq * 256 + blk * 16 + slot;
    if (dval && drdy) begin
      dst_count++;
      if (exp_ids.size() == 0) begin
        checks++;
        $display("FAIL dst_extra: got line %0h, expected none", cur_id);
      end else begin
        chk("dst_line", cur_id, exp_ids.pop_front());
      end
    end
    if (ex_dval && !drdy) exp_stalls++;
    case (phase)
      PH_IDLE: if (in_val) begin
        nb      = req_nb_q.pop_front();
        cur_d   = req_d_q.pop_front();
        req_seq++;
        blk     = 0;
        slot    = 0;
        phase   = PH_HDR;
      end
      PH_HDR: if (resp_rdy) begin
        phase = PH_STR;
        for (int b = 0; b < nb; b++)
          for (int s = 0; s < SL; s++)
            if (s < int'(cur_d[b*4 +: 4]) || s >= DL) exp_ids.push_back(req_seq * 256 + b * 16 + s);
      end
      default: if (uval && ex_urdy) begin
        if (slot == 0) sel_log.push_back(int'(sel));
        if (slot == SL - 1) begin
          exp_blocks++;
          if (blk == nb - 1) phase = PH_IDLE;
          else begin
            blk++;
            slot = 0;
          end
        end else begin
          slot++;
        end
      end
    endcase
  endtask

  task automatic run_all(input int budget);
    int n = 0;
    while ((req_nb_q.size() != 0 || phase != PH_IDLE) && n < budget) begin
      step();
      n++;
    end
    if (req_nb_q.size() != 0 || phase != PH_IDLE) begin
      checks++;
      $display("FAIL timeout: request not finished after %0d cycles, phase %0d", n, phase);
    end
    chk("dst_drained", exp_ids.size(), 0);
  endtask

  task automatic chk_sel(input string nm, input int exp[$]);
    chk({nm, "_count"}, sel_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < sel_log.size(); i++) chk(nm, sel_log[i], exp[i]);
  endtask

  task automatic scenario_two_blocks(input string nm);
    int e[$];
    p_uval = 100; p_drdy = 100; p_hrdy = 100;
    stall_budget = 7;
    sel_log.delete();
    dst_count = 0;
    push_req(2, 64'h24);
    run_all(300);
    chk({nm, "_dst_lines"}, dst_count, 10);
    e = '{0, 1};
    chk_sel({nm, "_sel"}, e);
`ifdef RS_OUT_CTRL_PERF_EN
    chk({nm, "_perf_blocks"}, perf_b, 2);
    chk({nm, "_perf_stalls"}, perf_s, 7);
`endif
  endtask

  initial begin
    int e[$];
    int guard;
    {in_val, last_data, last_pad, last_par, last_blk, uval, resp_rdy, drdy} = '0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'(outs_vec()), 32'(V_READY));
    chk("reset_sel", 32'(sel), 0);
    rst = 1'b1;

    scenario_two_blocks("s1");

    hdr_hold = 5;
    hdr_cycles = 0;
    push_req(1, 64'h1);
    run_all(100);
    chk("hdr_stall_cycles", hdr_cycles, 6);

    sel_log.delete();
    push_req(3, 64'h444);
    push_req(2, 64'h13);
    run_all(300);
    e = '{0, 1, 2, 0, 1};
    chk_sel("b2b_sel", e);

    sel_log.delete();
    push_req(5, 64'h12341);
    run_all(300);
    chk_sel("five_sel", e);

    p_uval = 70; p_drdy = 50; p_hrdy = 60;
    for (int r = 0; r < 10; r++) begin
      int n;
      logic [63:0] d;
      n = $urandom_range(7, 1);
      d = '0;
      for (int b = 0; b < n; b++) d[b*4 +: 4] = 4'($urandom_range(DL, 1));
      push_req(n, d);
    end
    run_all(8000);

    push_req(2, 64'h24);
    guard = 0;
    while (!(phase == PH_STR && slot >= DL) && guard < 400) begin
      step();
      guard++;
    end
    chk("reach_parity", 32'(phase == PH_STR && slot >= DL), 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_outputs", 32'(outs_vec()), 32'(V_READY));
    chk("midrst_sel", 32'(sel), 0);
`ifdef RS_OUT_CTRL_PERF_EN
    chk("midrst_perf_blocks", perf_b, 0);
    chk("midrst_perf_stalls", perf_s, 0);
`endif
    phase = PH_IDLE;
    exp_ids.delete();
    req_nb_q.delete();
    req_d_q.delete();
    exp_blocks = 0;
    exp_stalls = 0;
    stall_budget = 0;
    @(negedge clk);
    rst = 1'b1;

    scenario_two_blocks("after_rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule
